control_sequencer: RTL

Hardwired control unit for the single-bus CPU datapath. Fetches each instruction via PC/MAR/MDR/IR, decodes the 5-bit opcode in IR[31:27] and steps the datapath through per-class T-states (T0..T7), driving every register-enable, bus-select, ALU-op and memory strobe. It replaces bench-driven control sequences and sits beside the datapath, taking IR and the branch condition flag back from it.

---
 rtl/control_sequencer_pkg.sv | 45 ++++
 rtl/control_sequencer_opcode_class_decode.sv | 33 +++
 rtl/control_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: opcode map, step encoding, instruction classes.
// Optional MUL/DIV support is selected with CONTROL_SEQUENCER_MULDIV_EN (see opcode_class_decode).
// No logic here; constants and types only.
package control_sequencer_pkg;

  localparam int OPW = 5;
  localparam logic [OPW-1:0] ADD_OP = 5'b00011;

  // Opcode map, IR[31:27]
  localparam logic [OPW-1:0] OP_LD   = 5'd0;
  localparam logic [OPW-1:0] OP_LDI  = 5'd1;
  localparam logic [OPW-1:0] OP_ST   = 5'd2;
  localparam logic [OPW-1:0] OP_ADD  = 5'd3;
  localparam logic [OPW-1:0] OP_SUB  = 5'd4;
  localparam logic [OPW-1:0] OP_AND  = 5'd5;
  localparam logic [OPW-1:0] OP_OR   = 5'd6;
  localparam logic [OPW-1:0] OP_SHR  = 5'd7;
  localparam logic [OPW-1:0] OP_SHL  = 5'd8;
  localparam logic [OPW-1:0] OP_ROR  = 5'd9;
  localparam logic [OPW-1:0] OP_ROL  = 5'd10;
  localparam logic [OPW-1:0] OP_ADDI = 5'd11;
  localparam logic [OPW-1:0] OP_ANDI = 5'd12;
  localparam logic [OPW-1:0] OP_ORI  = 5'd13;
  localparam logic [OPW-1:0] OP_MUL  = 5'd14;
  localparam logic [OPW-1:0] OP_DIV  = 5'd15;
  localparam logic [OPW-1:0] OP_BR   = 5'd18;
  localparam logic [OPW-1:0] OP_JR   = 5'd19;
  localparam logic [OPW-1:0] OP_MFHI = 5'd23;
  localparam logic [OPW-1:0] OP_MFLO = 5'd24;
  localparam logic [OPW-1:0] OP_NOP  = 5'd25;
  localparam logic [OPW-1:0] OP_HALT = 5'd26;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  // Bit positions within the class one-hot vector
  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LDI, C_LD, C_ST, C_MULDIV,
    C_MFHI, C_MFLO, C_BR, C_JR, C_NOP, C_HALT
  } cls_e;

  localparam int NCLS = 12;

endpackage

// File: rtl/control_sequencer_opcode_class_decode.sv
// Combinational opcode -> instruction-class one-hot; undefined opcodes land in the NOP class.
// Zero latency. No handshake.
// CONTROL_SEQUENCER_MULDIV_EN adds the MUL/DIV class; without it MUL/DIV decode as NOP.
module control_sequencer_opcode_class_decode
  import control_sequencer_pkg::*;
(
  input  logic [OPW-1:0]  opcode,
  output logic [NCLS-1:0] cls_oh
);

  // Exactly one class bit is set for every opcode value
  always_comb begin
    cls_oh = '0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHL, OP_SHR, OP_ROL, OP_ROR: cls_oh[C_ALU_R]  = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI:       cls_oh[C_ALU_I]  = 1'b1;
      OP_LDI:                         cls_oh[C_LDI]    = 1'b1;
      OP_LD:                          cls_oh[C_LD]     = 1'b1;
      OP_ST:                          cls_oh[C_ST]     = 1'b1;
`ifdef CONTROL_SEQUENCER_MULDIV_EN
      OP_MUL, OP_DIV:                 cls_oh[C_MULDIV] = 1'b1;
`endif
      OP_MFHI:                        cls_oh[C_MFHI]   = 1'b1;
      OP_MFLO:                        cls_oh[C_MFLO]   = 1'b1;
      OP_BR:                          cls_oh[C_BR]     = 1'b1;
      OP_JR:                          cls_oh[C_JR]     = 1'b1;
      OP_HALT:                        cls_oh[C_HALT]   = 1'b1;
      default:                        cls_oh[C_NOP]    = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, per-class execute T3-T7, HALT on stop at an instruction boundary.
// Outputs are combinational from the step register and IR[31:27]; one instruction step per clock.
// No backpressure; stop is honoured only in the last step. Optional MUL/DIV: CONTROL_SEQUENCER_MULDIV_EN.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic           clock,
  input  logic           clear,
  input  logic [31:0]    IR,
  input  logic           con_ff,
  input  logic           stop,
  output logic           PCout,
  output logic           PCin,
  output logic           IncPC,
  output logic           MARin,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           RYin,
  output logic           RZin,
  output logic           RZLOout,
  output logic           RZHIout,
  output logic           HIin,
  output logic           LOin,
  output logic           HIout,
  output logic           LOout,
  output logic           Cout,
  output logic           CONin,
  output logic           gra,
  output logic           grb,
  output logic           grc,
  output logic           rin,
  output logic           rout,
  output logic           BAout,
  output logic           Read,
  output logic           Write,
  output logic [OPW-1:0] ops,
  output logic           run
);

  state_e          state_q, state_d;
  logic [NCLS-1:0] cls_oh;
  logic [OPW-1:0]  opcode;
  logic            last_step;
  logic            unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  control_sequencer_opcode_class_decode u_decode (
    .opcode (opcode),
    .cls_oh (cls_oh)
  );

  // Step register; clear drops straight to RST so every strobe falls without waiting for a clock
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= S_RST;
    else        state_q <= state_d;
  end

  // Next step and strobe decode. T2 already looks at IR so NOP-class words skip T3:
  // the datapath is expected to present the incoming word on IR during T2.
  always_comb begin
    state_d = state_q; last_step = 1'b0;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
    IRin = 1'b0; RYin = 1'b0; RZin = 1'b0; RZLOout = 1'b0; RZHIout = 1'b0; HIin = 1'b0;
    LOin = 1'b0; HIout = 1'b0; LOout = 1'b0; Cout = 1'b0; CONin = 1'b0; gra = 1'b0;
    grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0; BAout = 1'b0; Read = 1'b0;
    Write = 1'b0; ops = '0;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        RZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_d = S_T3;
        last_step = cls_oh[C_NOP];
      end
      S_T3: begin
        state_d = S_T4;
        if (cls_oh[C_ALU_R] || cls_oh[C_ALU_I]) begin
          grb = 1'b1; rout = 1'b1; RYin = 1'b1;
        end else if (cls_oh[C_LDI] || cls_oh[C_LD] || cls_oh[C_ST]) begin
          grb = 1'b1; BAout = 1'b1; RYin = 1'b1;
        end else if (cls_oh[C_MULDIV]) begin
          gra = 1'b1; rout = 1'b1; RYin = 1'b1;
        end else if (cls_oh[C_MFHI]) begin
          HIout = 1'b1; gra = 1'b1; rin = 1'b1; last_step = 1'b1;
        end else if (cls_oh[C_MFLO]) begin
          LOout = 1'b1; gra = 1'b1; rin = 1'b1; last_step = 1'b1;
        end else if (cls_oh[C_BR]) begin
          gra = 1'b1; rout = 1'b1; CONin = 1'b1;
        end else if (cls_oh[C_JR]) begin
          gra = 1'b1; rout = 1'b1; PCin = 1'b1; last_step = 1'b1;
        end else begin
          // HALT opcode (or a NOP word whose IR changed under us): end the instruction here
          last_step = 1'b1;
        end
      end
      S_T4: begin
        state_d = S_T5;
        if (cls_oh[C_ALU_R]) begin
          grc = 1'b1; rout = 1'b1; RZin = 1'b1; ops = opcode;
        end else if (cls_oh[C_ALU_I]) begin
          Cout = 1'b1; RZin = 1'b1; ops = opcode;
        end else if (cls_oh[C_LDI] || cls_oh[C_LD] || cls_oh[C_ST]) begin
          Cout = 1'b1; RZin = 1'b1; ops = ADD_OP;
        end else if (cls_oh[C_MULDIV]) begin
          grb = 1'b1; rout = 1'b1; RZin = 1'b1; ops = opcode;
        end else if (cls_oh[C_BR]) begin
          PCout = 1'b1; RYin = 1'b1;
        end
      end
      S_T5: begin
        state_d = S_T6;
        if (cls_oh[C_ALU_R] || cls_oh[C_ALU_I] || cls_oh[C_LDI]) begin
          RZLOout = 1'b1; gra = 1'b1; rin = 1'b1; last_step = 1'b1;
        end else if (cls_oh[C_LD] || cls_oh[C_ST]) begin
          RZLOout = 1'b1; MARin = 1'b1;
        end else if (cls_oh[C_MULDIV]) begin
          RZLOout = 1'b1; LOin = 1'b1;
        end else if (cls_oh[C_BR]) begin
          Cout = 1'b1; RZin = 1'b1; ops = ADD_OP;
        end
      end
      S_T6: begin
        state_d = S_T7;
        if (cls_oh[C_LD]) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (cls_oh[C_ST]) begin
          gra = 1'b1; rout = 1'b1; MDRin = 1'b1;
        end else if (cls_oh[C_MULDIV]) begin
          RZHIout = 1'b1; HIin = 1'b1; last_step = 1'b1;
        end else if (cls_oh[C_BR]) begin
          RZLOout = 1'b1; PCin = con_ff; last_step = 1'b1;
        end
      end
      S_T7: begin
        last_step = 1'b1;
        if (cls_oh[C_LD]) begin
          MDRout = 1'b1; gra = 1'b1; rin = 1'b1;
        end else if (cls_oh[C_ST]) begin
          MDRout = 1'b1; Write = 1'b1;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
    if (last_step) begin
      state_d = (stop || cls_oh[C_HALT]) ? S_HALT : S_T0;
    end
`ifndef CONTROL_SEQUENCER_MULDIV_EN
    HIin = 1'b0;
    LOin = 1'b0;
`endif
  end

  assign run = (state_q != S_RST) && (state_q != S_HALT);

endmodule
